// File: rtl/adc_sample_gen_if.sv
// Sample stream bundle: data, channel tag and frame marker with valid/ready.
// The master holds tdata/tuser/tlast stable while tvalid is high and tready is low.
interface adc_sample_gen_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
);
  logic [DATA_W-1:0] tdata;
  logic [CH_W-1:0]   tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/adc_sample_gen.sv
// Synthetic round-robin ADC source: one sample per DIV clocks, visible 1 cycle after the tick.
// Backpressure never stalls generation; a tick that meets a held sample is dropped and counted.
module adc_sample_gen #(
  parameter int          DATA_W    = 16,
  parameter int          NUM_CH    = 4,
  parameter int          DIV       = 100,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic                aclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   const_val,
  input  logic [DATA_W-1:0]   step,
  adc_sample_gen_if.master    m,
  output logic [15:0]         overrun_cnt,
  output logic [15:0]         frame_cnt
);
  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              sq_phase_q, sq_phase_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [CH_W-1:0]   tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic [15:0]       overrun_q, overrun_d;
  logic [15:0]       frame_q, frame_d;

  logic              tick;
  logic              frame_end;
  logic [DATA_W-1:0] sample;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    ch_d       = ch_q;
    ramp_d     = ramp_q;
    lfsr_d     = lfsr_q;
    sq_phase_d = sq_phase_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    overrun_d  = overrun_q;
    frame_d    = frame_q;

    tick      = enable && (div_cnt_q == DIV_LAST);
    frame_end = tick && (ch_q == CH_LAST);

    case (mode)
      2'd0:    sample = ramp_q;
      2'd1:    sample = const_val;
      2'd2:    sample = lfsr_q[DATA_W-1:0];
      default: sample = sq_phase_q ? (~const_val + DATA_W'(1)) : const_val;
    endcase

    if (!enable) begin
      div_cnt_d = '0;
      ch_d      = '0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
      if (mode == 2'd2)
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      // Generated time is real time: a blocked slot is lost, the held sample stays.
      if (tvalid_q && !m.tready) begin
        overrun_d = (overrun_q == 16'hFFFF) ? overrun_q : overrun_q + 16'd1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = sample;
        tuser_d  = ch_q;
        tlast_d  = (ch_q == CH_LAST);
      end
    end else if (tvalid_q && m.tready) begin
      tvalid_d = 1'b0;
    end

    if (frame_end) begin
      frame_d = frame_q + 16'd1;
      if (mode == 2'd0)
        ramp_d = ramp_q + step;
      if (mode == 2'd3)
        sq_phase_d = !sq_phase_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      ch_q       <= '0;
      ramp_q     <= '0;
      lfsr_q     <= SEED;
      sq_phase_q <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      overrun_q  <= '0;
      frame_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      ch_q       <= ch_d;
      ramp_q     <= ramp_d;
      lfsr_q     <= lfsr_d;
      sq_phase_q <= sq_phase_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
      frame_q    <= frame_d;
    end
  end

  assign m.tdata     = tdata_q;
  assign m.tuser     = tuser_q;
  assign m.tlast     = tlast_q;
  assign m.tvalid    = tvalid_q;
  assign overrun_cnt = overrun_q;
  assign frame_cnt   = frame_q;
endmodule

// File: doc/adc_sample_gen.md
Name: adc_sample_gen

Overview:
Parametrised synthetic multi-channel ADC sample source. It stands in for a real ADC front end during bring-up and verification of the downstream capture path (FIFO, DMA, correlation).
- Emits one sample every DIV clocks, round-robin across NUM_CH channels.
- Selectable data patterns.
- AXI-Stream-style valid/ready output with overrun accounting.

Parameters:
DATA_W, 16, sample width in bits; legal range 2..32.
NUM_CH, 4, number of channels per frame; legal range 1..16.
DIV, 100, aclk cycles per sample slot; legal range >= 2.
LFSR_SEED, 32'h1, initial value of the 32-bit LFSR; a seed of 0 is replaced by 1.
Localparam CH_W = max(1, clog2(NUM_CH)).

Ports:
aclk  in  1  clock
rst_n  in  1  reset; synchronous, active-low, sampled on posedge aclk
enable  in  1  run/stop for sample generation
mode  in  2  pattern: 0 ramp, 1 constant, 2 LFSR noise, 3 square
const_val  in  DATA_W  constant value (mode 1) and square amplitude (mode 3)
step  in  DATA_W  ramp increment per frame (mode 0)
m_tdata  out  DATA_W  sample value
m_tuser  out  CH_W  channel index of the sample
m_tlast  out  1  high on the sample from channel NUM_CH-1
m_tvalid  out  1  sample valid
m_tready  in  1  downstream accept
overrun_cnt  out  16  dropped-sample count; saturates at 16'hFFFF
frame_cnt  out  16  completed frames; wraps modulo 2^16

Behaviour:
Reset (rst_n low at a posedge) clears the following; reset mid-operation aborts any pending sample with no drain:
- div_cnt = 0, ch = 0, ramp = 0, sq_phase = 0, lfsr = LFSR_SEED (1 if the seed is 0).
- m_tdata = 0, m_tuser = 0, m_tlast = 0, m_tvalid = 0, overrun_cnt = 0, frame_cnt = 0.

Timing:
- With enable = 1, div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt == DIV-1) && enable.
- With enable = 0, div_cnt and ch are forced to 0. ramp, lfsr, sq_phase and counters hold.
- The output register keeps draining while enable = 0.
- On tick:
  - Sample for the current ch is computed.
  - ch advances; it wraps NUM_CH-1 -> 0.
  - At the wrap (frame end), frame_cnt increments.
- The sample appears on m_tdata / m_tvalid on the cycle after tick (1-cycle latency).
- First sample after enable rises: m_tvalid goes high DIV cycles after the first cycle enable = 1.

Patterns (mode and const_val are sampled at tick; a change applies from the next sample):
- mode 0, ramp: data = ramp. At frame end, ramp <= ramp + step, modulo 2^DATA_W.
- mode 1, constant: data = const_val.
- mode 2, LFSR noise: data = lfsr[DATA_W-1:0].
  - lfsr advances once per generated sample: 32-bit Galois, taps 32'h80200003. Right-shift; if bit0 was 1, XOR the taps.
  - lfsr holds in the other modes.
- mode 3, square: data = sq_phase ? (~const_val + 1) : const_val (two's complement). sq_phase toggles at frame end.
- The ramp accumulator updates only in mode 0. sq_phase updates only in mode 3.

Output handshake:
- Transfer occurs when m_tvalid && m_tready. After a transfer with no new tick, m_tvalid clears on the next cycle.
- m_tdata, m_tuser and m_tlast are stable while m_tvalid && !m_tready.
- Tick while m_tvalid = 1 and m_tready = 0: the new sample is dropped, the held sample is kept, and overrun_cnt increments, saturating at 16'hFFFF. ch, ramp, lfsr and frame_cnt still advance, because generated time is real time.
- Tick in the same cycle as a transfer: the new sample loads and there is no overrun.
- NUM_CH = 1: ch stays 0, m_tlast = 1 on every sample, and every sample is a frame end.

Test Plan:
1. DATA_W=16, NUM_CH=4, DIV=4, mode 0, step=1, m_tready=1, enable from reset.
   -> Samples (ch, data): (0,0) (1,0) (2,0) (3,0, tlast) (0,1)...
   -> Valid pulses are 4 cycles apart; frame_cnt = 3 after 12 samples.
2. mode 1, const_val=16'hABCD, m_tready held 0 for 20 cycles (DIV=4).
   -> The first sample (ch0, ABCD) is held and stable.
   -> overrun_cnt = 4 when m_tready rises.
   -> The next accepted sample carries ch = 1 (advanced by 5 ticks mod 4).
3. mode 2, LFSR_SEED=1, DATA_W=16.
   -> Data sequence 0x0001, 0x0003, 0x0002, 0x0001 (the low bits of the expected Galois states from the model); it must match the reference model for 64 samples.
   -> LFSR_SEED=0 gives the same sequence.
4. mode 3, const_val=100, NUM_CH=2.
   -> Frame 0 data 100,100; frame 1 0xFF9C,0xFF9C; frame 2 100,100.
5. Deassert enable mid-frame after the ch1 sample.
   -> No further ticks; the pending sample drains.
   -> On re-enable, the next sample is ch0 after DIV cycles, and the ramp value is unchanged.
6. Assert rst_n = 0 while m_tvalid = 1, with overrun_cnt = 7.
   -> Next cycle all outputs = 0.
   -> Force overrun past 65535 in a separate run: it holds at 16'hFFFF.
